// File: rtl/seq_div_8by4.sv
// Sequential restoring divider: 2N-bit dividend / N-bit divisor, one quotient bit per clock.
// Optional div_by_zero output port enabled by defining DIV_BYZERO_FLAG_EN.
module seq_div_8by4 #(
    parameter int unsigned N = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*N-1:0] dividend,
    input  logic [N-1:0]   divisor,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] quotient,
    output logic [N-1:0]   remainder
`ifdef DIV_BYZERO_FLAG_EN
    ,
    output logic           div_by_zero
`endif
);

    localparam int unsigned QW = 2 * N;
    localparam int unsigned RW = N + 1;
    localparam int unsigned CW = $clog2(QW);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_e;

    state_e         state_q, state_d;
    logic [QW-1:0]  dvd_q, dvd_d;
    logic [N-1:0]   dvs_q, dvs_d;
    logic [N-1:0]   rem_q, rem_d;
    logic [QW-1:0]  quo_q, quo_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           in_ready_q, in_ready_d;
    logic           out_valid_q, out_valid_d;
    logic [RW-1:0]  trial_c;
    logic [RW-1:0]  diff_c;
    logic           ge_c;
`ifdef DIV_BYZERO_FLAG_EN
    logic           dbz_q, dbz_d;
`endif

    // Partial remainder is kept at N bits: after each restore it is always below the divisor.
    always_comb begin
        trial_c = {rem_q, dvd_q[QW-1]};
        diff_c  = trial_c - {1'b0, dvs_q};
        ge_c    = (trial_c >= {1'b0, dvs_q});
    end

    always_comb begin
        state_d     = state_q;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        cnt_d       = cnt_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
`ifdef DIV_BYZERO_FLAG_EN
        dbz_d       = dbz_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    dvd_d      = dividend;
                    dvs_d      = divisor;
                    in_ready_d = 1'b0;
                    if (divisor != '0) begin
                        rem_d   = '0;
                        quo_d   = '0;
                        cnt_d   = '0;
                        state_d = CALC;
                    end else begin
                        // Divide by zero saturates the quotient and passes the low dividend bits through.
                        quo_d       = '1;
                        rem_d       = dividend[N-1:0];
                        out_valid_d = 1'b1;
`ifdef DIV_BYZERO_FLAG_EN
                        dbz_d       = 1'b1;
`endif
                        state_d     = DONE;
                    end
                end
            end
            CALC: begin
                dvd_d = {dvd_q[QW-2:0], 1'b0};
                quo_d = {quo_q[QW-2:0], ge_c};
                rem_d = ge_c ? diff_c[N-1:0] : trial_c[N-1:0];
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(QW - 1)) begin
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
`ifdef DIV_BYZERO_FLAG_EN
                    dbz_d       = 1'b0;
`endif
                    state_d     = IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            dvd_q       <= '0;
            dvs_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

`ifdef DIV_BYZERO_FLAG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dbz_q <= 1'b0;
        end else begin
            dbz_q <= dbz_d;
        end
    end

    assign div_by_zero = dbz_q;
`endif

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule
